// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, shift funct3 codes and the immediate-format enum
// used by the immediate generator and its extractor.
package imm_gen_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_ILL = 3'd7
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen_if.sv
// Fetch-side and operand-side valid/ready channels of the immediate generator.
// The master modport is the producer/consumer environment, slave is the block.
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

endinterface

// File: rtl/imm_extract.sv
// Combinational RV32I/RV64I immediate decoder: instruction word in,
// sign-extended immediate, format code and illegal flag out.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_e        o_fmt,
    output logic            o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [5:0] w_shamt;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    // RV32 shifts only own a 5-bit shamt; bit 25 belongs to funct7 there.
    assign w_shamt  = {(XLEN == 64) ? i_instr[25] : 1'b0, i_instr[24:20]};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        o_imm     = '0;
        o_fmt     = FMT_ILL;
        o_illegal = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                if (w_funct3 == F3_SLL || w_funct3 == F3_SRL_SRA) begin
                    o_fmt = FMT_SH;
                    o_imm = XLEN'(w_shamt);
                end else begin
                    o_fmt = FMT_I;
                    o_imm = XLEN'($signed(i_instr[31:20]));
                end
            end
            LOAD, JALR: begin
                o_fmt = FMT_I;
                o_imm = XLEN'($signed(i_instr[31:20]));
            end
            STORE: begin
                o_fmt = FMT_S;
                o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            end
            BRANCH: begin
                o_fmt = FMT_B;
                o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                       i_instr[11:8], 1'b0}));
            end
            LUI, AUIPC: begin
                o_fmt = FMT_U;
                o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
            end
            JAL: begin
                o_fmt = FMT_J;
                o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                       i_instr[30:21], 1'b0}));
            end
            OP: begin
                o_fmt = FMT_R;
            end
            default: begin
                o_fmt     = FMT_ILL;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes at acceptance into a two-entry
// in-order skid buffer and counts accepted illegal instructions.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    imm_gen_if.slave         bus,
    output logic [CNT_W-1:0] ill_count
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           r_head;
    entry_t           r_skid;
    logic             r_head_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_ill_count;

    entry_t          w_new;
    entry_t          w_head_nxt;
    entry_t          w_skid_nxt;
    logic            w_head_valid_nxt;
    logic            w_skid_valid_nxt;
    logic            w_in_fire;
    logic            w_out_fire;
    logic [XLEN-1:0] w_imm;
    imm_fmt_e        w_fmt;
    logic            w_illegal;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .i_instr   (bus.in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    assign w_new = '{imm: w_imm, fmt: w_fmt, illegal: w_illegal, tag: bus.in_tag};

    // A flush cycle refuses input even though in_ready may still read 1.
    assign w_in_fire  = bus.in_valid && r_in_ready && !flush;
    assign w_out_fire = r_head_valid && bus.out_ready;

    // The skid entry is only ever filled while the head is stalled, so when
    // it is valid the block is full and no input can arrive alongside it.
    always_comb begin
        w_head_nxt       = r_head;
        w_skid_nxt       = r_skid;
        w_head_valid_nxt = r_head_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_head_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                w_head_nxt       = r_skid;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_head_nxt = w_new;
            end else begin
                w_head_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            if (r_head_valid) begin
                w_skid_nxt       = w_new;
                w_skid_valid_nxt = 1'b1;
            end else begin
                w_head_nxt       = w_new;
                w_head_valid_nxt = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_head       <= w_head_nxt;
            r_head_valid <= w_head_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !(w_head_valid_nxt && w_skid_valid_nxt);
        end
    end

    // NOTE: the skid payload has no reset; it is never observed until r_skid_valid is set.
    always_ff @(posedge clk) begin
        r_skid <= w_skid_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_count <= '0;
        end else if (w_in_fire && w_illegal && !(&r_ill_count)) begin
            r_ill_count <= r_ill_count + 1'b1;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_head_valid;
    assign bus.out_imm     = r_head.imm;
    assign bus.out_fmt     = r_head.fmt;
    assign bus.out_illegal = r_head.illegal;
    assign bus.out_tag     = r_head.tag;
    assign ill_count       = r_ill_count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are scored against a queue-based reference model of the decoder/buffer.
module tb_imm_gen_pipe;

    localparam int TAG_W = 4;
    localparam int CW32  = 16;
    localparam int CW64  = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [CW32-1:0] cnt32;
    logic [CW64-1:0] cnt64;

    imm_gen_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

    assign if64.in_valid  = if32.in_valid;
    assign if64.in_instr  = if32.in_instr;
    assign if64.in_tag    = if32.in_tag;
    assign if64.out_ready = if32.out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CW32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (if32.slave),
        .ill_count (cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CW64)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (if64.slave),
        .ill_count (cnt64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } txn_t;

    txn_t q[$];
    int   exp_cnt32;
    int   exp_cnt64;
    logic exp_in_ready;
    int   n_checks;
    int   n_errors;
    int   dut_accepted;

    logic [6:0] ops [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
        case (ins[6:0])
            7'h13:        return (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 3'd6 : 3'd1;
            7'h03, 7'h67: return 3'd1;
            7'h23:        return 3'd2;
            7'h63:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6f:        return 3'd5;
            7'h33:        return 3'd0;
            default:      return 3'd7;
        endcase
    endfunction

    // Interpret a raw field value as a two's-complement number of 'bits' bits.
    function automatic longint as_signed(input longint raw, input int bits);
        longint span;
        span = longint'(1) <<< bits;
        return (raw >= span / 2) ? raw - span : raw;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xlen);
        longint      v;
        logic [63:0] r;
        v = 0;
        case (ref_fmt(ins))
            3'd1: v = as_signed(longint'(ins[31:20]), 12);
            3'd2: v = as_signed(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            3'd3: v = as_signed(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                                + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            3'd4: v = as_signed(longint'(ins[31:12]) * 4096, 32);
            3'd5: v = as_signed(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                                + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            3'd6: v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
            default: v = 0;
        endcase
        r = 64'(v);
        if (xlen == 32) r = {32'h0, r[31:0]};
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) r[6:0] = ops[k];
        return r;
    endfunction

    task automatic check_outputs();
        txn_t t;
        check("valid32", 64'(if32.out_valid), 64'(q.size() > 0));
        check("valid64", 64'(if64.out_valid), 64'(q.size() > 0));
        check("in_ready32", 64'(if32.in_ready), 64'(exp_in_ready));
        check("in_ready64", 64'(if64.in_ready), 64'(exp_in_ready));
        check("ill_count32", 64'(cnt32), 64'(exp_cnt32));
        check("ill_count64", 64'(cnt64), 64'(exp_cnt64));
        if (q.size() > 0) begin
            t = q[0];
            check("imm32", 64'(if32.out_imm), ref_imm(t.instr, 32));
            check("imm64", if64.out_imm, ref_imm(t.instr, 64));
            check("fmt32", 64'(if32.out_fmt), 64'(ref_fmt(t.instr)));
            check("fmt64", 64'(if64.out_fmt), 64'(ref_fmt(t.instr)));
            check("illegal32", 64'(if32.out_illegal), 64'(ref_fmt(t.instr) == 3'd7));
            check("tag32", 64'(if32.out_tag), 64'(t.tag));
            check("tag64", 64'(if64.out_tag), 64'(t.tag));
        end
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, then score.
    task automatic step(input logic v, input logic [31:0] ins, input logic [TAG_W-1:0] tag,
                        input logic ordy, input logic fl);
        logic in_fire;
        logic out_fire;
        if32.in_valid  = v;
        if32.in_instr  = ins;
        if32.in_tag    = tag;
        if32.out_ready = ordy;
        flush          = fl;
        if (v && if32.in_ready && !fl) dut_accepted++;
        in_fire  = v && exp_in_ready && !fl;
        out_fire = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back('{instr: ins, tag: tag});
        end
        if (in_fire && ref_fmt(ins) == 3'd7) begin
            exp_cnt32 = (exp_cnt32 < 65535) ? exp_cnt32 + 1 : exp_cnt32;
            exp_cnt64 = (exp_cnt64 < 7) ? exp_cnt64 + 1 : exp_cnt64;
        end
        exp_in_ready = q.size() < 2;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_values();
        check("rst_valid32", 64'(if32.out_valid), 64'(0));
        check("rst_ready32", 64'(if32.in_ready), 64'(0));
        check("rst_imm32", 64'(if32.out_imm), 64'(0));
        check("rst_fmt32", 64'(if32.out_fmt), 64'(0));
        check("rst_ill32", 64'(if32.out_illegal), 64'(0));
        check("rst_tag32", 64'(if32.out_tag), 64'(0));
        check("rst_cnt32", 64'(cnt32), 64'(0));
        check("rst_valid64", 64'(if64.out_valid), 64'(0));
        check("rst_imm64", if64.out_imm, 64'(0));
        check("rst_cnt64", 64'(cnt64), 64'(0));
    endtask

    task automatic idle_inputs();
        if32.in_valid  = 1'b0;
        if32.in_instr  = '0;
        if32.in_tag    = '0;
        if32.out_ready = 1'b1;
        flush          = 1'b0;
    endtask

    logic [31:0] d_ins   [9] = '{32'h001B0B13, 32'h002B1513, 32'h00053483, 32'h01849663,
                                 32'hFE0006E3, 32'h01950533, 32'h800002B7, 32'hFFDFF06F,
                                 32'h0000007F};
    logic [31:0] d_imm32 [9] = '{32'h1, 32'h2, 32'h0, 32'hC, 32'hFFFFFFEC, 32'h0,
                                 32'h80000000, 32'hFFFFFFFC, 32'h0};
    logic [63:0] d_imm64 [9] = '{64'h1, 64'h2, 64'h0, 64'hC, 64'hFFFFFFFFFFFFFFEC, 64'h0,
                                 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC, 64'h0};
    logic [2:0]  d_fmt   [9] = '{3'd1, 3'd6, 3'd1, 3'd3, 3'd3, 3'd0, 3'd4, 3'd5, 3'd7};

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        exp_cnt32    = 0;
        exp_cnt64    = 0;
        exp_in_ready = 1'b0;
        dut_accepted = 0;
        idle_inputs();

        #3;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

        // Directed vectors with the consumer always ready.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, d_ins[i], TAG_W'(i), 1'b1, 1'b0);
            check("dir_imm32", 64'(if32.out_imm), 64'(d_imm32[i]));
            check("dir_imm64", if64.out_imm, d_imm64[i]);
            check("dir_fmt", 64'(if32.out_fmt), 64'(d_fmt[i]));
            check("dir_tag", 64'(if32.out_tag), 64'(i));
        end
        check("ill_first_flag", 64'(if32.out_illegal), 64'(1));
        check("ill_first_cnt", 64'(cnt32), 64'(1));

        // Saturation of the narrow counter on the 64-bit instance.
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0000007F, TAG_W'(i), 1'b1, 1'b0);
        check("ill_sat64", 64'(cnt64), 64'(7));
        check("ill_cnt32", 64'(cnt32), 64'(9));
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

        // Back-pressure: only head and skid may fill.
        dut_accepted = 0;
        for (int i = 0; i < 5; i++) step(1'b1, rand_instr(), TAG_W'(10 + i), 1'b0, 1'b0);
        check("bp_accepted", 64'(dut_accepted), 64'(2));
        check("bp_in_ready", 64'(if32.in_ready), 64'(0));
        check("bp_head_tag", 64'(if32.out_tag), 64'(10));
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        check("bp_second_tag", 64'(if32.out_tag), 64'(11));
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        check("bp_drained", 64'(if32.out_valid), 64'(0));

        // Flush with both entries full and a valid input in the flush cycle.
        step(1'b1, rand_instr(), 4'd3, 1'b0, 1'b0);
        step(1'b1, rand_instr(), 4'd4, 1'b0, 1'b0);
        step(1'b1, 32'h01849663, 4'd5, 1'b0, 1'b1);
        check("flush_valid", 64'(if32.out_valid), 64'(0));
        check("flush_ready", 64'(if32.in_ready), 64'(1));
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes and stalls.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), TAG_W'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset in the middle of a stalled stream.
        step(1'b1, rand_instr(), 4'd1, 1'b0, 1'b0);
        step(1'b1, rand_instr(), 4'd2, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        exp_cnt32    = 0;
        exp_cnt64    = 0;
        exp_in_ready = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        step(1'b1, 32'h01849663, 4'd9, 1'b1, 1'b0);
        check("post_rst_valid", 64'(if32.out_valid), 64'(1));
        check("post_rst_imm", 64'(if32.out_imm), 64'hC);
        check("post_rst_tag", 64'(if32.out_tag), 64'(9));
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
